// File: rtl/sisc_ctrl_hs.sv
// sisc_ctrl_hs: multi-cycle SISC control FSM with a request/ready memory
// handshake, LOD/STR/SWP sequencing, wait-state timeout and sticky HALT.
module sisc_ctrl_hs #(
  parameter int          CCW      = 4,
  parameter int unsigned AM_IMM   = 8,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [3:0]     opcode,
  input  logic [CCW-1:0] mm,
  input  logic [CCW-1:0] stat,
  input  logic           mem_rdy,
  output logic           rf_we,
  output logic           wb_sel,
  output logic           rb_sel,
  output logic           pc_sel,
  output logic           pc_write,
  output logic           pc_rst,
  output logic           ir_load,
  output logic           br_sel,
  output logic [1:0]     alu_op,
  output logic           mem_req,
  output logic           mm_sel,
  output logic           dm_we,
  output logic           halted,
  output logic           fault,
  output logic           illegal
);

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // A zero WAIT_MAX would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIM   = CNT_W'(WAIT_MAX);
  localparam logic [CCW-1:0]   IMM_MODE   = CCW'(AM_IMM);
  localparam bit               TIMEOUT_EN = (WAIT_MAX > 0);

  typedef enum logic [3:0] {
    START0  = 4'd0,
    START1  = 4'd1,
    FETCH   = 4'd2,
    DECODE  = 4'd3,
    EXECUTE = 4'd4,
    MEM     = 4'd5,
    WB      = 4'd6,
    WB2     = 4'd7,
    HALT    = 4'd8
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             cc_hit;
  logic             imm_mode;

  assign cc_hit   = |(stat & mm);
  assign imm_mode = (mm == IMM_MODE);

  // State register; reset parks the controller in START0.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= START0;
    else        state <= state_next;
  end

  // Wait-state counter and sticky fault flag; a fresh count starts per state.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (state_next != state || mem_rdy) wait_cnt <= '0;
      else if (mem_req)                   wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout) fault <= 1'b1;
    end
  end

  // Next-state and datapath control decode from the current state and IR.
  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    rb_sel     = 1'b0;
    pc_sel     = 1'b0;
    pc_write   = 1'b0;
    pc_rst     = 1'b0;
    ir_load    = 1'b0;
    br_sel     = 1'b0;
    alu_op     = 2'b00;
    mem_req    = 1'b0;
    mm_sel     = 1'b0;
    dm_we      = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;

    if (state == EXECUTE || state == MEM || state == WB || state == WB2) begin
      if (opcode == OP_ALU) alu_op = imm_mode ? 2'b01 : 2'b00;
      else                  alu_op = imm_mode ? 2'b11 : 2'b10;
    end

    case (state)
      START0: begin
        pc_rst     = 1'b1;
        state_next = START1;
      end
      START1: state_next = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        ir_load  = mem_rdy;
        pc_write = mem_rdy;
        if (mem_rdy) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_BRA: if (cc_hit) begin pc_write = 1'b1; pc_sel = 1'b1; end
          OP_BRR: begin
            br_sel = 1'b1;
            if (cc_hit) begin pc_write = 1'b1; pc_sel = 1'b1; end
          end
          OP_BNE: if (!cc_hit) begin pc_write = 1'b1; pc_sel = 1'b1; end
          OP_BNR: begin
            br_sel = 1'b1;
            if (!cc_hit) begin pc_write = 1'b1; pc_sel = 1'b1; end
          end
          OP_NOOP, OP_LOD, OP_STR, OP_SWP, OP_ALU, OP_HLT: ;
          default: illegal = 1'b1;
        endcase
        state_next = (opcode == OP_HLT) ? HALT : EXECUTE;
      end
      EXECUTE: state_next = MEM;
      MEM: begin
        if (opcode == OP_LOD || opcode == OP_STR) begin
          mem_req = 1'b1;
          mm_sel  = 1'b1;
          dm_we   = (opcode == OP_STR);
          if (mem_rdy) state_next = WB;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        state_next = FETCH;
        case (opcode)
          OP_ALU: rf_we = 1'b1;
          OP_LOD: begin rf_we = 1'b1; wb_sel = 1'b1; end
          OP_SWP: begin rf_we = 1'b1; state_next = WB2; end
          default: ;
        endcase
      end
      WB2: begin
        rf_we      = 1'b1;
        rb_sel     = 1'b1;
        state_next = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_next = START0;
    endcase

    if (TIMEOUT_EN && mem_req && !mem_rdy && wait_cnt == WAIT_LIM) begin
      timeout    = 1'b1;
      state_next = HALT;
    end
  end

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// tb_sisc_ctrl_hs: directed-vector bench for sisc_ctrl_hs with WAIT_MAX=4.
module tb_sisc_ctrl_hs;

  localparam logic [15:0] RF_WE    = 16'h8000;
  localparam logic [15:0] WB_SEL   = 16'h4000;
  localparam logic [15:0] RB_SEL   = 16'h2000;
  localparam logic [15:0] PC_SEL   = 16'h1000;
  localparam logic [15:0] PC_WRITE = 16'h0800;
  localparam logic [15:0] PC_RST   = 16'h0400;
  localparam logic [15:0] IR_LOAD  = 16'h0200;
  localparam logic [15:0] BR_SEL   = 16'h0100;
  localparam logic [15:0] ALU11    = 16'h00C0;
  localparam logic [15:0] ALU10    = 16'h0080;
  localparam logic [15:0] ALU01    = 16'h0040;
  localparam logic [15:0] MEM_REQ  = 16'h0020;
  localparam logic [15:0] MM_SEL   = 16'h0010;
  localparam logic [15:0] DM_WE    = 16'h0008;
  localparam logic [15:0] HALTED   = 16'h0004;
  localparam logic [15:0] FAULT    = 16'h0002;
  localparam logic [15:0] ILLEGAL  = 16'h0001;
  localparam logic [15:0] F_OK     = MEM_REQ | IR_LOAD | PC_WRITE;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       mem_rdy;
  logic       rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel;
  logic [1:0] alu_op;
  logic       mem_req, mm_sel, dm_we, halted, fault, illegal;
  logic [15:0] ctrl;
  int checks = 0;
  int errors = 0;

  sisc_ctrl_hs #(.CCW(4), .AM_IMM(8), .WAIT_MAX(4)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_rdy(mem_rdy), .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel),
    .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load),
    .br_sel(br_sel), .alu_op(alu_op), .mem_req(mem_req), .mm_sel(mm_sel),
    .dm_we(dm_we), .halted(halted), .fault(fault), .illegal(illegal)
  );

  assign ctrl = {rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel,
                 alu_op, mem_req, mm_sel, dm_we, halted, fault, illegal};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] m, input logic rdy);
    opcode  = op;
    mm      = m;
    mem_rdy = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%04h expected=%04h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check combinational controls mid-cycle, advance.
  task automatic cyc(input string tag, input logic [3:0] op, input logic [3:0] m,
                     input logic rdy, input logic [15:0] expected);
    applyStimulus(op, m, rdy);
    #1;
    checkOutput(tag, ctrl, expected);
    @(posedge clk);
    #1;
  endtask

  // Directed sequence covering reset, every opcode class, waits and timeout.
  initial begin
    rst_f = 1'b1;
    stat  = 4'b0000;
    applyStimulus(4'd0, 4'd0, 1'b1);
    #2 rst_f = 1'b0;
    #1 checkOutput("reset_async", ctrl, PC_RST);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", ctrl, PC_RST);
    end
    rst_f = 1'b1;

    cyc("start0", 4'd0, 4'd0, 1'b1, PC_RST);
    cyc("start1", 4'd0, 4'd0, 1'b1, 16'h0000);
    cyc("noop_fetch", 4'd0, 4'd0, 1'b1, F_OK);
    cyc("noop_decode", 4'd0, 4'd0, 1'b1, 16'h0000);
    cyc("noop_exec", 4'd0, 4'd0, 1'b1, ALU10);
    cyc("noop_mem", 4'd0, 4'd0, 1'b1, ALU10);
    cyc("noop_wb", 4'd0, 4'd0, 1'b1, ALU10);
    cyc("fetch_wait", 4'd0, 4'd0, 1'b0, MEM_REQ);
    cyc("fetch_done", 4'd0, 4'd0, 1'b1, F_OK);
    cyc("noop2_decode", 4'd0, 4'd0, 1'b1, 16'h0000);
    cyc("noop2_exec", 4'd0, 4'd0, 1'b1, ALU10);
    cyc("noop2_mem", 4'd0, 4'd0, 1'b1, ALU10);
    cyc("noop2_wb", 4'd0, 4'd0, 1'b1, ALU10);

    cyc("alui_fetch", 4'd8, 4'd8, 1'b1, F_OK);
    cyc("alui_decode", 4'd8, 4'd8, 1'b1, 16'h0000);
    cyc("alui_exec", 4'd8, 4'd8, 1'b1, ALU01);
    cyc("alui_mem", 4'd8, 4'd8, 1'b1, ALU01);
    cyc("alui_wb", 4'd8, 4'd8, 1'b1, RF_WE | ALU01);
    cyc("alur_fetch", 4'd8, 4'd0, 1'b1, F_OK);
    cyc("alur_decode", 4'd8, 4'd0, 1'b1, 16'h0000);
    cyc("alur_exec", 4'd8, 4'd0, 1'b1, 16'h0000);
    cyc("alur_mem", 4'd8, 4'd0, 1'b1, 16'h0000);
    cyc("alur_wb", 4'd8, 4'd0, 1'b1, RF_WE);

    stat = 4'b0100;
    cyc("bra_fetch", 4'd4, 4'b0100, 1'b1, F_OK);
    cyc("bra_taken", 4'd4, 4'b0100, 1'b1, PC_WRITE | PC_SEL);
    cyc("bra_exec", 4'd4, 4'b0100, 1'b1, ALU10);
    cyc("bra_mem", 4'd4, 4'b0100, 1'b1, ALU10);
    cyc("bra_wb", 4'd4, 4'b0100, 1'b1, ALU10);
    cyc("bnr_fetch", 4'd7, 4'b0100, 1'b1, F_OK);
    cyc("bnr_not_taken", 4'd7, 4'b0100, 1'b1, BR_SEL);
    cyc("bnr_exec", 4'd7, 4'b0100, 1'b1, ALU10);
    cyc("bnr_mem", 4'd7, 4'b0100, 1'b1, ALU10);
    cyc("bnr_wb", 4'd7, 4'b0100, 1'b1, ALU10);
    cyc("brr_fetch", 4'd5, 4'b0001, 1'b1, F_OK);
    cyc("brr_not_taken", 4'd5, 4'b0001, 1'b1, BR_SEL);
    cyc("brr_exec", 4'd5, 4'b0001, 1'b1, ALU10);
    cyc("brr_mem", 4'd5, 4'b0001, 1'b1, ALU10);
    cyc("brr_wb", 4'd5, 4'b0001, 1'b1, ALU10);
    cyc("bne_fetch", 4'd6, 4'b0001, 1'b1, F_OK);
    cyc("bne_taken", 4'd6, 4'b0001, 1'b1, PC_WRITE | PC_SEL);
    cyc("bne_exec", 4'd6, 4'b0001, 1'b1, ALU10);
    cyc("bne_mem", 4'd6, 4'b0001, 1'b1, ALU10);
    cyc("bne_wb", 4'd6, 4'b0001, 1'b1, ALU10);
    stat = 4'b0000;

    cyc("lod_fetch", 4'd1, 4'd0, 1'b1, F_OK);
    cyc("lod_decode", 4'd1, 4'd0, 1'b1, 16'h0000);
    cyc("lod_exec_rdy_ignored", 4'd1, 4'd0, 1'b0, ALU10);
    for (int i = 0; i < 3; i++) cyc("lod_mem_wait", 4'd1, 4'd0, 1'b0, MEM_REQ | MM_SEL | ALU10);
    cyc("lod_mem_done", 4'd1, 4'd0, 1'b1, MEM_REQ | MM_SEL | ALU10);
    cyc("lod_wb", 4'd1, 4'd0, 1'b1, RF_WE | WB_SEL | ALU10);

    cyc("str_fetch", 4'd2, 4'd0, 1'b1, F_OK);
    cyc("str_decode", 4'd2, 4'd0, 1'b1, 16'h0000);
    cyc("str_exec", 4'd2, 4'd0, 1'b1, ALU10);
    for (int i = 0; i < 2; i++) cyc("str_mem_wait", 4'd2, 4'd0, 1'b0, MEM_REQ | MM_SEL | DM_WE | ALU10);
    cyc("str_mem_done", 4'd2, 4'd0, 1'b1, MEM_REQ | MM_SEL | DM_WE | ALU10);
    cyc("str_wb", 4'd2, 4'd0, 1'b1, ALU10);

    cyc("lodb_fetch", 4'd1, 4'd0, 1'b1, F_OK);
    cyc("lodb_decode", 4'd1, 4'd0, 1'b1, 16'h0000);
    cyc("lodb_exec", 4'd1, 4'd0, 1'b1, ALU10);
    for (int i = 0; i < 4; i++) cyc("lodb_mem_wait", 4'd1, 4'd0, 1'b0, MEM_REQ | MM_SEL | ALU10);
    cyc("lodb_rdy_at_limit", 4'd1, 4'd0, 1'b1, MEM_REQ | MM_SEL | ALU10);
    cyc("lodb_wb", 4'd1, 4'd0, 1'b1, RF_WE | WB_SEL | ALU10);

    cyc("lodi_fetch", 4'd1, 4'd8, 1'b1, F_OK);
    cyc("lodi_decode", 4'd1, 4'd8, 1'b1, 16'h0000);
    cyc("lodi_exec", 4'd1, 4'd8, 1'b1, ALU11);
    cyc("lodi_mem", 4'd1, 4'd8, 1'b1, MEM_REQ | MM_SEL | ALU11);
    cyc("lodi_wb", 4'd1, 4'd8, 1'b1, RF_WE | WB_SEL | ALU11);

    cyc("swp_fetch", 4'd3, 4'd0, 1'b1, F_OK);
    cyc("swp_decode", 4'd3, 4'd0, 1'b1, 16'h0000);
    cyc("swp_exec", 4'd3, 4'd0, 1'b1, ALU10);
    cyc("swp_mem", 4'd3, 4'd0, 1'b1, ALU10);
    cyc("swp_wb", 4'd3, 4'd0, 1'b1, RF_WE | ALU10);
    cyc("swp_wb2", 4'd3, 4'd0, 1'b1, RF_WE | RB_SEL | ALU10);

    cyc("ill_fetch", 4'd9, 4'd0, 1'b1, F_OK);
    cyc("ill_decode", 4'd9, 4'd0, 1'b1, ILLEGAL);
    cyc("ill_exec", 4'd9, 4'd0, 1'b1, ALU10);
    cyc("ill_mem", 4'd9, 4'd0, 1'b1, ALU10);
    cyc("ill_wb", 4'd9, 4'd0, 1'b1, ALU10);

    cyc("hlt_fetch", 4'd15, 4'd0, 1'b1, F_OK);
    cyc("hlt_decode", 4'd15, 4'd0, 1'b1, 16'h0000);
    cyc("hlt_halt0", 4'd15, 4'd0, 1'b1, HALTED);
    cyc("hlt_halt1", 4'd0, 4'd8, 1'b0, HALTED);
    cyc("hlt_halt2", 4'd1, 4'd0, 1'b1, HALTED);
    cyc("hlt_halt3", 4'd8, 4'd8, 1'b0, HALTED);

    rst_f = 1'b0;
    #1 checkOutput("halt_reset", ctrl, PC_RST);
    @(posedge clk);
    #1 rst_f = 1'b1;
    cyc("to_start0", 4'd0, 4'd0, 1'b0, PC_RST);
    cyc("to_start1", 4'd0, 4'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) cyc("to_fetch_wait", 4'd0, 4'd0, 1'b0, MEM_REQ);
    cyc("to_fault0", 4'd0, 4'd0, 1'b0, HALTED | FAULT);
    cyc("to_fault1", 4'd0, 4'd0, 1'b1, HALTED | FAULT);
    cyc("to_fault2", 4'd1, 4'd0, 1'b0, HALTED | FAULT);

    rst_f = 1'b0;
    #1 checkOutput("fault_reset", ctrl, PC_RST);
    @(posedge clk);
    #1 rst_f = 1'b1;
    cyc("rec_start0", 4'd0, 4'd0, 1'b0, PC_RST);
    cyc("rec_start1", 4'd0, 4'd0, 1'b0, 16'h0000);
    cyc("rec_fetch_wait", 4'd0, 4'd0, 1'b0, MEM_REQ);
    cyc("rec_fetch_wait", 4'd0, 4'd0, 1'b0, MEM_REQ);
    rst_f = 1'b0;
    #1 checkOutput("reset_mid_access", ctrl, PC_RST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl_hs.md
# sisc_ctrl_hs

Multi-cycle control FSM for the SISC datapath, successor to the fixed-timing controller. It decodes the instruction held in the IR and sequences fetch/decode/execute/mem/writeback. It also adds a request/ready memory handshake with wait states, full LOD/STR/SWP sequencing, a parametrised wait-state timeout with a fault halt, and a sticky HALT state. It sits between the IR/status register and the PC, register file, ALU and memory-interface muxes.

## Interface
- `CCW`, default 4: width of condition-code mask `mm` and status `stat`.
- `AM_IMM`, default 8: `mm` value that selects immediate addressing.
- `WAIT_MAX`, default 15: maximum consecutive cycles `mem_rdy` may stay low during a request before a fault. 0 disables the timeout.
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `rst_f`, input, 1: asynchronous, active-low reset.
- `opcode`, input, 4: IR[31:28].
- `mm`, input, CCW: IR condition/addressing field.
- `stat`, input, CCW: status register.
- `mem_rdy`, input, 1: memory completes the current request this cycle.
- `rf_we`, `wb_sel`, `rb_sel`, `pc_sel`, `pc_write`, `pc_rst`, `ir_load`, `br_sel`, output, 1 each: datapath controls, meanings as in the current SISC datapath.
- `alu_op`, output, 2: ALU function select.
- `mem_req`, output, 1: memory access request.
- `mm_sel`, output, 1: memory address source. 0 = PC, 1 = ALU result.
- `dm_we`, output, 1: data-memory write enable.
- `halted`, output, 1: controller is in HALT.
- `fault`, output, 1: sticky wait-state timeout flag.
- `illegal`, output, 1: one-cycle pulse when an undefined opcode is seen in DECODE.

## Operation
- **States:** START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT. The state register is 4 bits.
- **Outputs:** all outputs are combinational from the registered state plus `opcode`/`mm`/`stat`/`mem_rdy`. Any output not listed for a state is 0.
- **Opcodes:** NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. All others are treated as NOOP and pulse `illegal`.
- **START0:** `pc_rst`=1. Next state START1.
- **START1:** all outputs 0. Next state FETCH.
- **FETCH:** `mem_req`=1, `mm_sel`=0. `ir_load`=`pc_write`=`mem_rdy`.
  - Stay in FETCH while `mem_rdy`=0.
  - Go to DECODE when `mem_rdy`=1.
- **DECODE, branch taken:** `pc_write`=`pc_sel`=1.
  - BRA and BRR are taken when (`stat` & `mm`) != 0.
  - BNE and BNR are taken when (`stat` & `mm`) == 0.
- **DECODE, branch select:** `br_sel`=1 for BRR/BNR (relative) and 0 for BRA/BNE (absolute). `br_sel` is driven whether or not the branch is taken.
- **DECODE, next state:**
  - HLT goes to HALT.
  - Every other opcode goes to EXECUTE.
- **alu_op:** valid in EXECUTE, MEM, WB and WB2; 00 in all other states.
  - ALU opcode: 01 if `mm`==AM_IMM, else 00.
  - Any other opcode: 11 if `mm`==AM_IMM, else 10.
- **EXECUTE:** next state MEM.
- **MEM, LOD/STR:** `mem_req`=1, `mm_sel`=1. STR also drives `dm_we`=1.
  - Stay in MEM until `mem_rdy`=1.
- **MEM, other opcodes:** no request. Next state WB after one cycle.
- **WB:**
  - ALU: `rf_we`=1, `wb_sel`=0.
  - LOD: `rf_we`=1, `wb_sel`=1.
  - SWP: `rf_we`=1, `rb_sel`=0, then go to WB2.
  - Anything else: no write.
  - Next state FETCH, except SWP.
- **WB2 (SWP only):** `rf_we`=1, `rb_sel`=1. Next state FETCH.
- **HALT:** `halted`=1, all other controls 0. Only `rst_f` exits HALT.
- **Wait counter:**
  - Width is $clog2(WAIT_MAX+1).
  - Increments every cycle that `mem_req`=1 and `mem_rdy`=0.
  - Clears on `mem_rdy`=1 and on any state change.
- **Timeout:** when the counter reaches WAIT_MAX (WAIT_MAX>0) with `mem_rdy` still 0, set `fault`=1 and go to HALT on the next edge.

## Timing
- **Reset:** `rst_f` low forces state START0 immediately (asynchronous) and clears `fault` and the counter.
  - While in reset: `pc_rst`=1, all other outputs 0.
  - Reset mid-access drops `mem_req` combinationally.
- **After reset release:** first rising edge goes to START1; second edge goes to FETCH.
- **Latency with `mem_rdy` tied high:**
  - 5 cycles per instruction (FETCH, DECODE, EXECUTE, MEM, WB).
  - SWP takes 6 cycles.
  - Each low cycle of `mem_rdy` adds one cycle.
- **Handshake:**
  - `mem_req` and its qualifiers (`mm_sel`, `dm_we`) stay stable until the cycle in which `mem_rdy`=1.
  - `mem_rdy` sampled while `mem_req`=0 is ignored.
- **Timeout example:** with WAIT_MAX=N and `mem_rdy` held low, `mem_req` is high for exactly N+1 cycles, then HALT with `fault`=1.
- **`mem_rdy` and timeout on the same edge:** `mem_rdy`=1 in the cycle the counter reaches WAIT_MAX completes normally; no fault.

## Test plan
- **Reset and NOOP stream:** hold `rst_f`=0 for 3 cycles, release, `mem_rdy`=1, `opcode`=0 → `pc_rst`=1 only in START0; first `ir_load` pulse 2 cycles after release; `pc_write` pulses every 5 cycles; no `rf_we`.
- **ALU immediate:** `opcode`=8, `mm`=8 → `alu_op`=01 in EXECUTE; in WB, `rf_we`=1 and `wb_sel`=0.
- **Branches:** `stat`=4'b0100.
  - BRA with `mm`=4'b0100 → taken: `pc_sel`=`pc_write`=1, `br_sel`=0.
  - BNR with `mm`=4'b0100 → not taken: `pc_write`=0 in DECODE, `br_sel`=1.
- **LOD with wait states:** `mem_rdy` low for 3 cycles in MEM → `mem_req`=`mm_sel`=1 for 4 cycles; instruction takes 8 cycles; WB shows `rf_we`=`wb_sel`=1. STR shows `dm_we`=1 during its MEM wait.
- **Timeout and reset recovery:** WAIT_MAX=4, `mem_rdy`=0 in FETCH → `mem_req` high 5 cycles, then `fault`=`halted`=1. Asserting `rst_f`=0 clears both.
- **SWP, HLT and illegal opcodes:**
  - SWP → WB `rb_sel`=0, WB2 `rb_sel`=1, `rf_we` high both cycles.
  - `opcode`=15 → `halted`=1 from the cycle after DECODE, held indefinitely.
  - `opcode`=9 → one-cycle `illegal` pulse in DECODE, then sequenced as NOOP.
